aes_round_sequencer: RTL and testbench
======================================

// Module: aes_round_sequencer
// PURPOSE
//  Parametrised AES round sequencer, successor to the fixed 4-bit round counter.
//  Supports AES-128/192/256 (10/12/14 rounds) and counts up for encrypt, down for decrypt.
//  Adds a start/busy/done handshake, stall, abort and first/last-round flags.
//  Drives the round index for the datapath and key schedule.
// PARAMETERS
//  CNT_W   4   round index width; must satisfy 2**CNT_W > max(NR_*) (elaboration check)
//  NR_128  10  final round index for key_len=2'b00
//  NR_192  12  final round index for key_len=2'b01
//  NR_256  14  final round index for key_len=2'b10; 2'b11 is reserved and decodes as NR_128
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request new operation; sampled in IDLE or DONE only
//  key_len      in   2      key size, sampled with an accepted start
//  decrypt      in   1      1 = count NR..0, 0 = count 0..NR; sampled with an accepted start
//  stall        in   1      hold round/state for this cycle (RUN only)
//  abort        in   1      synchronous cancel; returns to IDLE
//  round        out  CNT_W  current round index
//  busy         out  1      high in RUN
//  first_round  out  1      high in RUN while round==start value (0 enc / NR dec)
//  last_round   out  1      high in RUN while round==end value (NR enc / 0 dec)
//  done         out  1      one-cycle pulse in DONE
// BEHAVIOUR
//  - Reset (async assert, sync to clk edge on release): state=IDLE, round=0; busy, done, first_round and last_round=0.
//  - States: IDLE -> RUN on start; RUN -> DONE after the last round advances; DONE -> IDLE, or DONE -> RUN on start.
//  - Accepted start at edge T:
//    - Latches nr (from key_len) and dir.
//    - round=0 (enc) or nr (dec) from T+1; busy=1 and first_round=1 at T+1.
//  - RUN, stall=0: round increments (enc) or decrements (dec) each cycle.
//  - RUN, stall=1: round, state and flags are held.
//  - RUN at end value with stall=0: next state is DONE; round holds the end value; busy=0, done=1.
//  - Latency, unstalled: nr+1 RUN cycles; done asserts nr+2 cycles after start is accepted (AES-128: 12).
//  - DONE lasts exactly one cycle.
//    - start in DONE: goes directly to RUN (back-to-back, no idle bubble).
//    - No start: goes to IDLE with round=0.
//  - start while in RUN is ignored; mode/dir inputs are ignored outside an accepted start.
//  - abort, any state: next cycle IDLE, round=0, all flags 0. abort beats start and stall in the same cycle.
//  - stall in IDLE/DONE has no effect.
//  - Width: round is never loaded beyond nr and never wraps; there is no modular arithmetic.
//  - key_len=2'b11 is treated as 2'b00; no error output.
//  - Flags and done are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package aes_pkg holds:
//    - KEYLEN_128/192/256 encodings and NR_* defaults.
//    - Function nr_of(key_len).
//    - State localparams IDLE/RUN/DONE (2-bit).
//  - Single flat module with one state register, one round register and latched nr/dir. No sub-module.
// TESTING
//  - Enc AES-128: start=1 for 1 cycle, key_len=00, decrypt=0 -> round 0..10 on 11 consecutive cycles; first_round with 0, last_round with 10; done pulse at cycle 12; then round=0.
//  - Dec AES-256: key_len=10, decrypt=1 -> round 14..0; first_round at 14, last_round at 0; done after 16 cycles.
//  - Stall: AES-192 enc, stall=1 for 3 cycles at round=5 -> round holds 5 for 3 cycles; done is 3 cycles later than nominal (cycle 17).
//  - Back-to-back: start held high through DONE -> DONE lasts 1 cycle; next cycle round=0, busy=1 with no IDLE cycle; start pulses during RUN do not restart.
//  - Abort/priority: abort with start at round=7 -> next cycle IDLE, round=0, done never pulses; rst asserted mid-RUN -> outputs 0 immediately (async).
//  - Reserved key_len=11 -> behaves as AES-128 (last round 10).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared encodings for the AES round sequencer: key-length codes, default
// final-round indices and the sequencer state codes.
package aes_pkg;

    localparam logic [1:0] KEYLEN_128 = 2'b00;
    localparam logic [1:0] KEYLEN_192 = 2'b01;
    localparam logic [1:0] KEYLEN_256 = 2'b10;

    localparam int NR_128_DEFAULT = 10;
    localparam int NR_192_DEFAULT = 12;
    localparam int NR_256_DEFAULT = 14;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // The reserved code 2'b11 falls back to the AES-128 round count.
    function automatic int nr_of(input logic [1:0] key_len);
        case (key_len)
            KEYLEN_192: nr_of = NR_192_DEFAULT;
            KEYLEN_256: nr_of = NR_256_DEFAULT;
            default:    nr_of = NR_128_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks the round index 0..NR (encrypt) or NR..0 (decrypt)
// with start/busy/done handshake, stall, abort and first/last-round flags.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int NR_128 = nr_of(KEYLEN_128),
    parameter int NR_192 = nr_of(KEYLEN_192),
    parameter int NR_256 = nr_of(KEYLEN_256)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             decrypt,
    input  logic             stall,
    input  logic             abort,
    output logic [CNT_W-1:0] round,
    output logic             busy,
    output logic             first_round,
    output logic             last_round,
    output logic             done
);

    localparam int MAX_NR = (NR_128 > NR_192) ? ((NR_128 > NR_256) ? NR_128 : NR_256)
                                              : ((NR_192 > NR_256) ? NR_192 : NR_256);

    if ((2 ** CNT_W) <= MAX_NR) begin : g_width_check
        $error("aes_round_sequencer: CNT_W too narrow for the largest round count");
    end

    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] NR128_C = CNT_W'(NR_128);
    localparam logic [CNT_W-1:0] NR192_C = CNT_W'(NR_192);
    localparam logic [CNT_W-1:0] NR256_C = CNT_W'(NR_256);

    function automatic logic [CNT_W-1:0] nr_sel(input logic [1:0] kl);
        case (kl)
            KEYLEN_192: nr_sel = NR192_C;
            KEYLEN_256: nr_sel = NR256_C;
            default:    nr_sel = NR128_C;
        endcase
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] round_r, round_s;
    logic [CNT_W-1:0] nr_r, nr_s;
    logic             dir_r, dir_s;
    logic [CNT_W-1:0] end_r_s;
    logic             busy_r, done_r, first_r, last_r;
    logic             first_s, last_s;

    assign end_r_s = dir_r ? ZERO_C : nr_r;

    // Next-state and next-round decode; abort overrides start and stall.
    always_comb begin
        state_s = state_r;
        round_s = round_r;
        nr_s    = nr_r;
        dir_s   = dir_r;
        if (abort) begin
            state_s = IDLE;
            round_s = ZERO_C;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_s = RUN;
                        nr_s    = nr_sel(key_len);
                        dir_s   = decrypt;
                        round_s = decrypt ? nr_sel(key_len) : ZERO_C;
                    end else begin
                        state_s = IDLE;
                        round_s = ZERO_C;
                    end
                end
                RUN: begin
                    if (stall) begin
                        state_s = RUN;
                    end else if (round_r == end_r_s) begin
                        state_s = DONE;
                    end else if (dir_r) begin
                        round_s = round_r - ONE_C;
                    end else begin
                        round_s = round_r + ONE_C;
                    end
                end
                default: begin
                    state_s = IDLE;
                    round_s = ZERO_C;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they can be registered alongside it.
    always_comb begin
        first_s = (state_s == RUN) && (round_s == (dir_s ? nr_s : ZERO_C));
        last_s  = (state_s == RUN) && (round_s == (dir_s ? ZERO_C : nr_s));
    end

    // State, round, latched mode and registered output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            round_r <= ZERO_C;
            nr_r    <= ZERO_C;
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            round_r <= round_s;
            nr_r    <= nr_s;
            dir_r   <= dir_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            first_r <= first_s;
            last_r  <= last_s;
        end
    end

    assign round       = round_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign first_round = first_r;
    assign last_round  = last_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer.
module tb_aes_round_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] key_len;
    logic       decrypt;
    logic       stall;
    logic       abort;
    logic [3:0] round;
    logic       busy;
    logic       first_round;
    logic       last_round;
    logic       done;

    int n_checks;
    int n_fail;

    aes_round_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_len     (key_len),
        .decrypt     (decrypt),
        .stall       (stall),
        .abort       (abort),
        .round       (round),
        .busy        (busy),
        .first_round (first_round),
        .last_round  (last_round),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_round"}, 32'(round), 32'd0);
        check_eq({tag, "_busy"},  32'(busy), 32'd0);
        check_eq({tag, "_done"},  32'(done), 32'd0);
        check_eq({tag, "_first"}, 32'(first_round), 32'd0);
        check_eq({tag, "_last"},  32'(last_round), 32'd0);
    endtask

    // Runs one operation and leaves the bench in the DONE cycle.
    task automatic run_op(input logic [1:0] kl, input logic dec, input int nr,
                          input int stall_at, input int stall_len, input logic hold_start);
        int r;
        int cyc;
        start   = 1'b1;
        key_len = kl;
        decrypt = dec;
        tick();
        start   = hold_start;
        key_len = kl ^ 2'b01;
        decrypt = ~dec;
        cyc = 1;
        for (int i = 0; i <= nr; i++) begin
            r = dec ? (nr - i) : i;
            check_eq("run_round", 32'(round), 32'(r));
            check_eq("run_busy",  32'(busy), 32'd1);
            check_eq("run_first", 32'(first_round), 32'(i == 0));
            check_eq("run_last",  32'(last_round), 32'(i == nr));
            check_eq("run_done",  32'(done), 32'd0);
            if (r == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    stall = 1'b1;
                    tick();
                    cyc++;
                    check_eq("stall_round", 32'(round), 32'(r));
                    check_eq("stall_busy",  32'(busy), 32'd1);
                    check_eq("stall_done",  32'(done), 32'd0);
                end
                stall = 1'b0;
            end
            tick();
            cyc++;
        end
        key_len = kl;
        decrypt = dec;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy",  32'(busy), 32'd0);
        check_eq("done_round", 32'(round), dec ? 32'd0 : 32'(nr));
        check_eq("done_first", 32'(first_round), 32'd0);
        check_eq("done_last",  32'(last_round), 32'd0);
        check_eq("done_cycle", 32'(cyc), 32'(nr + 2 + stall_len));
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'b00;
        decrypt  = 1'b0;
        stall    = 1'b0;
        abort    = 1'b0;
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // stall in IDLE does nothing
        stall = 1'b1;
        tick();
        tick();
        check_idle("idle_stall");
        stall = 1'b0;

        // AES-128 encrypt: rounds 0..10, done in cycle 12, then IDLE
        run_op(2'b00, 1'b0, 10, -1, 0, 1'b0);
        tick();
        check_idle("enc128_after");

        // AES-256 decrypt: rounds 14..0, done in cycle 16
        run_op(2'b10, 1'b1, 14, -1, 0, 1'b0);
        tick();
        check_idle("dec256_after");

        // AES-192 encrypt with 3-cycle stall at round 5: done in cycle 17
        run_op(2'b01, 1'b0, 12, 5, 3, 1'b0);
        tick();
        check_idle("stall192_after");

        // Reserved key length behaves as AES-128
        run_op(2'b11, 1'b0, 10, -1, 0, 1'b0);
        tick();
        check_idle("kl11_after");

        // Back-to-back: start held through RUN and DONE
        run_op(2'b00, 1'b0, 10, -1, 0, 1'b1);
        tick();
        check_eq("b2b_round", 32'(round), 32'd0);
        check_eq("b2b_busy",  32'(busy), 32'd1);
        check_eq("b2b_first", 32'(first_round), 32'd1);
        check_eq("b2b_done",  32'(done), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_abort_round", 32'(round), 32'd7);

        // abort beats start in the same cycle; done never pulses afterwards
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_idle("abort");
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) done_seen++;
        end
        check_eq("abort_no_done", 32'(done_seen), 32'd0);

        // Asynchronous reset mid-RUN clears outputs before the next edge
        start   = 1'b1;
        key_len = 2'b00;
        decrypt = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("pre_rst_round", 32'(round), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check_idle("rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
